// File: rtl/imem_responder.sv
// imem_responder: loadable instruction memory with a wait-state fetch port.
// Ports: clk_i/rst_i clock and sync active-high reset;
//   m_addr_i/m_rden_i fetch request, m_dout_o/m_hit_o registered fetch result;
//   ld_en_i/ld_addr_i/ld_data_i loader write, ld_done_i releases the core to RUN;
//   ld_err_o sticky rejected-load flag; busy_o high while loading.
module imem_responder #(
  parameter int AddrWidth = 32,
  parameter int InstrWidth = 32,
  parameter int Depth = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int WaitStates = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [AddrWidth-1:0]  m_addr_i,
  input  logic                  m_rden_i,
  output logic [InstrWidth-1:0] m_dout_o,
  output logic                  m_hit_o,
  input  logic                  ld_en_i,
  input  logic [AddrWidth-1:0]  ld_addr_i,
  input  logic [InstrWidth-1:0] ld_data_i,
  input  logic                  ld_done_i,
  output logic                  ld_err_o,
  output logic                  busy_o
);
  localparam int IdxW = $clog2(Depth);
  localparam logic [AddrWidth:0] Span = (AddrWidth+1)'(Depth) << 2;
  localparam logic [2:0] Ws = 3'(WaitStates);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state;
  logic [InstrWidth-1:0] mem [Depth];
  logic [AddrWidth-1:0] last_addr, m_off, ld_off;
  logic last_rden, m_ok, ld_ok, hit;
  logic [2:0] cnt, ncnt;
  // Offsets wrap below BaseAddr, so a single unsigned compare covers both range ends.
  always_comb begin
    m_off = m_addr_i - BaseAddr;
    ld_off = ld_addr_i - BaseAddr;
    m_ok = m_addr_i[1:0] == 2'b00 && {1'b0, m_off} < Span;
    ld_ok = ld_addr_i[1:0] == 2'b00 && {1'b0, ld_off} < Span;
    ncnt = (m_rden_i && last_rden && m_addr_i == last_addr) ? (cnt >= Ws ? Ws : cnt + 3'd1) : 3'd0;
    hit = state == RUN && m_rden_i && m_ok && ncnt == Ws;
  end
  // Memory has no reset so contents survive rst_i.
  always_ff @(posedge clk_i)
    if (!rst_i && state == LOAD && ld_en_i && ld_ok) mem[ld_off[IdxW+1:2]] <= ld_data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= LOAD;
      busy_o <= 1'b1;
      m_hit_o <= 1'b0;
      m_dout_o <= '0;
      ld_err_o <= 1'b0;
      cnt <= 3'd0;
      last_rden <= 1'b0;
      last_addr <= '0;
    end else begin
      last_addr <= m_addr_i;
      last_rden <= m_rden_i;
      cnt <= ncnt;
      m_hit_o <= hit;
      m_dout_o <= hit ? mem[m_off[IdxW+1:2]] : '0;
      if (ld_en_i && (state == RUN || !ld_ok)) ld_err_o <= 1'b1;
      if (state == LOAD && ld_done_i) begin
        state <= RUN;
        busy_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: scoreboard bench driving a 0- and a 3-wait-state instance in lockstep.
module tb_imem_responder;
  typedef struct packed {
    logic h0;
    logic [31:0] d0;
    logic h3;
    logic [31:0] d3;
    logic busy;
    logic err;
  } exp_t;
  logic clk = 0, rst = 0, rden = 0, ld_en = 0, ld_done = 0;
  logic [31:0] addr = 0, ld_addr = 0, ld_data = 0;
  logic [31:0] dout0, dout3;
  logic hit0, hit3, err0, err3, busy0, busy3;
  logic eb = 1, ee = 0;
  int tests = 0, fails = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  imem_responder #(.AddrWidth(32), .InstrWidth(32), .Depth(16), .BaseAddr(32'h0), .WaitStates(0)) u0 (
    .clk_i(clk), .rst_i(rst), .m_addr_i(addr), .m_rden_i(rden), .m_dout_o(dout0), .m_hit_o(hit0),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_done_i(ld_done),
    .ld_err_o(err0), .busy_o(busy0));
  imem_responder #(.AddrWidth(32), .InstrWidth(32), .Depth(16), .BaseAddr(32'h0), .WaitStates(3)) u3 (
    .clk_i(clk), .rst_i(rst), .m_addr_i(addr), .m_rden_i(rden), .m_dout_o(dout3), .m_hit_o(hit3),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_done_i(ld_done),
    .ld_err_o(err3), .busy_o(busy3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic exp_t mk(input logic h0, input logic [31:0] d0, input logic h3, input logic [31:0] d3);
    return '{h0: h0, d0: d0, h3: h3, d3: d3, busy: eb, err: ee};
  endfunction
  task automatic cyc(input logic r, input logic rd, input logic [31:0] a, input logic le,
                     input logic [31:0] la, input logic [31:0] ld, input logic dn, input exp_t e);
    exp_t x;
    rst = r; rden = rd; addr = a; ld_en = le; ld_addr = la; ld_data = ld; ld_done = dn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("hit_ws0", 32'(hit0), 32'(x.h0));
    check("dout_ws0", dout0, x.d0);
    check("hit_ws3", 32'(hit3), 32'(x.h3));
    check("dout_ws3", dout3, x.d3);
    check("busy", {30'd0, busy3, busy0}, {30'd0, x.busy, x.busy});
    check("ld_err", {30'd0, err3, err0}, {30'd0, x.err, x.err});
  endtask
  // Hold a fresh read address for n cycles; the 3-wait instance hits from the 4th cycle on.
  task automatic rd(input logic [31:0] a, input int n, input logic ok, input logic [31:0] w);
    for (int i = 0; i < n; i++)
      cyc(0, 1, a, 0, 0, 0, 0, mk(ok, ok ? w : 32'h0, ok && i >= 3, (ok && i >= 3) ? w : 32'h0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0));
    cyc(0, 1, 0, 1, 32'h0, 32'h00000013, 0, mk(0, 0, 0, 0));
    cyc(0, 1, 0, 1, 32'h4, 32'h00100093, 0, mk(0, 0, 0, 0));
    cyc(0, 0, 0, 1, 32'hC, 32'h11111111, 0, mk(0, 0, 0, 0));
    eb = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0));
    rd(32'h0, 1, 1, 32'h00000013);
    rd(32'h4, 5, 1, 32'h00100093);
    rd(32'h0, 2, 1, 32'h00000013);
    rd(32'h4, 4, 1, 32'h00100093);
    cyc(0, 0, 32'h4, 0, 0, 0, 0, mk(0, 0, 0, 0));
    rd(32'h4, 4, 1, 32'h00100093);
    rd(32'h2, 4, 0, 0);
    rd(32'h40, 4, 0, 0);
    ee = 1;
    cyc(0, 0, 0, 1, 32'hC, 32'hBAD, 0, mk(0, 0, 0, 0));
    rd(32'hC, 4, 1, 32'h11111111);
    rd(32'h0, 2, 1, 32'h00000013);
    eb = 1; ee = 0;
    cyc(1, 1, 32'h0, 1, 32'h0, 32'hFFFFFFFF, 1, mk(0, 0, 0, 0));
    cyc(0, 1, 32'h0, 0, 0, 0, 0, mk(0, 0, 0, 0));
    ee = 1;
    cyc(0, 0, 0, 1, 32'h6, 32'hCAFE, 0, mk(0, 0, 0, 0));
    eb = 0;
    cyc(0, 0, 0, 1, 32'h8, 32'hDEADBEEF, 1, mk(0, 0, 0, 0));
    rd(32'h8, 4, 1, 32'hDEADBEEF);
    rd(32'h0, 4, 1, 32'h00000013);
    rd(32'h4, 4, 1, 32'h00100093);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, byte-address width of the fetch and load ports.
REQ-002 SHALL have parameter InstrWidth, default 32, instruction word width in bits.
REQ-003 SHALL have parameter Depth, default 1024, number of InstrWidth words stored; power of two.
REQ-004 SHALL have parameter BaseAddr, default 32'h0000_0000, byte address of word 0; Depth*4-aligned.
REQ-005 SHALL have parameter WaitStates, default 0, range 0..7, extra cycles a read address must be held before a hit.
REQ-006 SHALL have ports (one clock, clk_i; reset rst_i is synchronous and active-high):
  clk_i  in  1  system clock
  rst_i  in  1  synchronous active-high reset
  m_addr_i  in  AddrWidth  fetch byte address
  m_rden_i  in  1  fetch read enable
  m_dout_o  out  InstrWidth  fetched instruction
  m_hit_o  out  1  m_dout_o valid
  ld_en_i  in  1  loader write strobe
  ld_addr_i  in  AddrWidth  loader byte address
  ld_data_i  in  InstrWidth  loader word
  ld_done_i  in  1  loader finished, release core
  ld_err_o  out  1  sticky: loader write rejected
  busy_o  out  1  high while not in RUN

Function
REQ-007 SHALL implement FSM LOAD -> RUN; reset enters LOAD; LOAD -> RUN on edge with ld_done_i=1; RUN stays until reset.
REQ-008 SHALL in LOAD write mem[(ld_addr_i-BaseAddr)>>2] <= ld_data_i on edge with ld_en_i=1, address aligned and in range.
REQ-009 SHALL set ld_err_o on edge with ld_en_i=1 and address misaligned, out of range, or state RUN; no write occurs; cleared only by reset.
REQ-010 SHALL, when ld_en_i and ld_done_i are high on the same edge in LOAD, perform the write and then enter RUN.
REQ-011 SHALL hold m_hit_o=0 and m_dout_o=0 throughout LOAD regardless of m_rden_i.
REQ-012 SHALL keep registers last_addr, last_rden, cnt (3 bits); each edge: last_addr<=m_addr_i, last_rden<=m_rden_i.
REQ-013 SHALL compute ncnt = (m_rden_i && last_rden && m_addr_i==last_addr) ? min(cnt+1, WaitStates) : 0; cnt<=ncnt each edge; saturates at WaitStates, never wraps.
REQ-014 SHALL in RUN, on each edge, register m_hit_o <= m_rden_i && aligned && in range && ncnt==WaitStates.
REQ-015 SHALL register m_dout_o <= mem word at m_addr_i when the hit condition is true, else 0.
REQ-016 SHALL give latency 1+WaitStates edges from first sampling of a new address to m_hit_o=1; with WaitStates=0 a new address hits every cycle.
REQ-017 SHALL, if m_addr_i changes or m_rden_i drops mid-wait, restart the count from 0 and drop m_hit_o on the next edge.
REQ-018 SHALL keep m_hit_o=1 and m_dout_o stable each cycle while the same address remains requested after a hit.
REQ-019 SHALL treat misaligned (m_addr_i[1:0]!=0) or out-of-range addresses as miss: m_hit_o=0, m_dout_o=0, no error flag.
REQ-020 SHALL set busy_o=1 in LOAD, 0 in RUN, registered with the state.

Reset
REQ-021 SHALL on edge with rst_i=1 set state=LOAD, m_hit_o=0, m_dout_o=0, ld_err_o=0, busy_o=1, cnt=0, last_rden=0.
REQ-022 SHALL not clear memory contents on reset; contents persist across reset.
REQ-023 SHALL let rst_i override all other inputs on that edge, including mid-wait and same-edge ld_en_i/ld_done_i (no write).

Verification
REQ-024 Load 0x00000013 at 0x0, 0x00100093 at 0x4, pulse ld_done_i, WaitStates=0, request 0x0 then 0x4 -> hit=1 with 0x00000013 then 0x00100093 on consecutive cycles.
REQ-025 WaitStates=3, hold 0x4 -> m_hit_o=0 for 3 cycles, 1 on 4th with 0x00100093; change address at cycle 2 -> count restarts, no hit until 4 cycles later.
REQ-026 In RUN request 0x2 and BaseAddr+Depth*4 -> m_hit_o=0, m_dout_o=0, ld_err_o=0.
REQ-027 ld_en_i in RUN, or at 0x6 in LOAD -> ld_err_o=1 sticky, target word unchanged on read-back.
REQ-028 Assert rst_i mid-wait in RUN -> next cycle busy_o=1, m_hit_o=0; after ld_done_i, 0x0 still returns 0x00000013.
REQ-029 ld_en_i and ld_done_i same edge at 0x8 with 0xDEADBEEF -> busy_o=0 next cycle, read 0x8 returns 0xDEADBEEF.
